// File: rtl/spi_display_gen.sv
// -----------------------------------------------------------------------------
// spi_display_gen
//
// Parametrised bit-bang SPI transmitter for display controllers. Words of the
// form {dc, data} are pulled from a FIFO/ROM-style source with a get/empty
// handshake and serialised onto SPI. Every half-bit is paced by an external
// step strobe; the FSM only moves on clock edges where step=1.
//
// Parameters:
//   W          data bits per word (1..32)
//   CPOL       idle level of spi_clock
//   CPHA       0 = sample on leading edge, 1 = sample on trailing edge
//   LSB_FIRST  0 = MSB shifted first, 1 = LSB shifted first
//   CS_GAP     step ticks spent in GAP (spi_cs_n high) before IDLE (1..255)
//
// Optional feature macro: SPI_DISPLAY_CS_SPLIT_EN
//   Defined   - a word whose dc differs from the current spi_dc is never
//               chained; the frame closes (HOLD -> GAP) and the word starts
//               from IDLE, so spi_cs_n toggles on every dc change.
//   Undefined - chaining ignores dc; spi_dc updates at the word boundary
//               while spi_cs_n stays low.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high
//   step       half-bit timing strobe
//   dc, data   presented word (valid when empty=0)
//   empty      source has no word
//   get        combinational consume pulse (source advances after this edge)
//   spi_cs_n   chip select, active low (registered)
//   spi_clock  SPI clock (registered)
//   spi_dc     data/command line, held for the whole word (registered)
//   spi_mosi   serial data out (registered)
//   busy       high whenever the FSM is not in IDLE (registered)
// -----------------------------------------------------------------------------
module spi_display_gen #(
    parameter int W         = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 0,
    parameter int CS_GAP    = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         step,
    input  logic         dc,
    input  logic [W-1:0] data,
    input  logic         empty,
    output logic         get,
    output logic         spi_cs_n,
    output logic         spi_clock,
    output logic         spi_dc,
    output logic         spi_mosi,
    output logic         busy
);

    localparam int   CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic CLK_IDLE = CPOL[0];
    // Clock level during phase A; phase B is its complement.
    localparam logic CLK_A    = CPOL[0] ^ CPHA[0];

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t        state;
    logic          phase_b;
    logic [W-1:0]  sreg;
    logic [CW-1:0] bit_cnt;
    logic [7:0]    gap_cnt;

    logic          last_bit;
    logic          chain_ok;
    logic          take;
    logic [W-1:0]  shifted;
    logic          first_bit;
    logic          next_bit;

    always_comb begin
        // NOTE: every variable gets a value on every path before any branch,
        // otherwise synthesis infers a latch to hold the old value.
        last_bit  = (bit_cnt == '0);
        shifted   = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
        first_bit = (LSB_FIRST != 0) ? data[0] : data[W-1];
        next_bit  = (LSB_FIRST != 0) ? shifted[0] : shifted[W-1];
`ifdef SPI_DISPLAY_CS_SPLIT_EN
        chain_ok  = (dc == spi_dc);
`else
        chain_ok  = 1'b1;
`endif
        // Consume only on a step tick, with a word present, outside reset,
        // either from IDLE or on phase B of the last bit of the current word.
        take = step && !empty && !reset &&
               ((state == IDLE) ||
                ((state == SHIFT) && phase_b && last_bit && chain_ok));
    end

    assign get = take;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase_b   <= 1'b0;
            sreg      <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            spi_cs_n  <= 1'b1;
            spi_clock <= CLK_IDLE;
            spi_dc    <= 1'b0;
            spi_mosi  <= 1'b0;
            busy      <= 1'b0;
        end else if (step) begin
            case (state)
                IDLE: begin
                    if (take) begin
                        sreg      <= data;
                        spi_mosi  <= first_bit;
                        spi_dc    <= dc;
                        spi_cs_n  <= 1'b0;
                        spi_clock <= CLK_A;
                        phase_b   <= 1'b0;
                        bit_cnt   <= CW'(W - 1);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!phase_b) begin
                        phase_b   <= 1'b1;
                        spi_clock <= ~CLK_A;
                    end else if (!last_bit) begin
                        // mosi only moves on entry to phase A
                        sreg      <= shifted;
                        spi_mosi  <= next_bit;
                        bit_cnt   <= bit_cnt - 1'b1;
                        phase_b   <= 1'b0;
                        spi_clock <= CLK_A;
                    end else if (take) begin
                        // chain next word without releasing chip select
                        sreg      <= data;
                        spi_mosi  <= first_bit;
                        spi_dc    <= dc;
                        bit_cnt   <= CW'(W - 1);
                        phase_b   <= 1'b0;
                        spi_clock <= CLK_A;
                    end else begin
                        spi_clock <= CLK_IDLE;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    spi_cs_n <= 1'b1;
                    gap_cnt  <= 8'(CS_GAP);
                    state    <= GAP;
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_display_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_display_gen
//
// Two instances: dut_a (W=8, mode 0, MSB first, CS_GAP=2) and dut_b (W=9,
// CPOL=1, CPHA=1, LSB first, CS_GAP=3). Each has an array-backed word source
// and an expected-word FIFO. The stimulus process pushes words into the source
// and their expected {dc, data} into the FIFO; a per-DUT monitor acts as an
// SPI slave, assembles words on the sampling edge and pops/compares them.
// Frame statistics gathered by the monitors are checked against hand-computed
// values after each scenario. Inputs change 1 time unit after the rising edge;
// monitors sample on the falling edge.
// -----------------------------------------------------------------------------
module tb_spi_display_gen;

    logic clk = 1'b0;
    logic rst;
    logic step;
    bit   step_always = 1'b0;

    initial forever #5 clk = ~clk;

    // step strobe: every other clock, or constantly high
    initial begin
        step = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (step_always) step = 1'b1;
            else             step = ~step;
        end
    end

    // ---------------- DUT A ----------------
    logic [8:0] mem_a [0:31];
    int         wr_a = 0;
    int         rd_a = 0;
    logic       a_dc, a_empty, a_get, a_cs_n, a_sclk, a_dc_o, a_mosi, a_busy;
    logic [7:0] a_data;

    assign a_empty = (rd_a == wr_a);
    assign a_dc    = mem_a[rd_a[4:0]][8];
    assign a_data  = mem_a[rd_a[4:0]][7:0];
    always @(posedge clk) if (a_get) rd_a <= rd_a + 1;

    spi_display_gen #(.W(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .CS_GAP(2)) dut_a (
        .clock(clk), .reset(rst), .step(step), .dc(a_dc), .data(a_data),
        .empty(a_empty), .get(a_get), .spi_cs_n(a_cs_n), .spi_clock(a_sclk),
        .spi_dc(a_dc_o), .spi_mosi(a_mosi), .busy(a_busy));

    // ---------------- DUT B ----------------
    logic [9:0] mem_b [0:31];
    int         wr_b = 0;
    int         rd_b = 0;
    logic       b_dc, b_empty, b_get, b_cs_n, b_sclk, b_dc_o, b_mosi, b_busy;
    logic [8:0] b_data;

    assign b_empty = (rd_b == wr_b);
    assign b_dc    = mem_b[rd_b[4:0]][9];
    assign b_data  = mem_b[rd_b[4:0]][8:0];
    always @(posedge clk) if (b_get) rd_b <= rd_b + 1;

    spi_display_gen #(.W(9), .CPOL(1), .CPHA(1), .LSB_FIRST(1), .CS_GAP(3)) dut_b (
        .clock(clk), .reset(rst), .step(step), .dc(b_dc), .data(b_data),
        .empty(b_empty), .get(b_get), .spi_cs_n(b_cs_n), .spi_clock(b_sclk),
        .spi_dc(b_dc_o), .spi_mosi(b_mosi), .busy(b_busy));

    // ---------------- scoreboards ----------------
    logic [8:0] exp_a [0:31];
    int         ewr_a = 0;
    int         erd_a = 0;
    logic [9:0] exp_b [0:31];
    int         ewr_b = 0;
    int         erd_b = 0;

    int tests = 0;
    int fails = 0;

    // ---------------- monitor A (mode 0, MSB first: sample on rising) -------
    int         mt_a = 0, mf_a = 0;
    int         bits_a = 0, samp_a = 0, low_a = 0, gap_a = 0;
    int         gets_a = 0, gets_busy_a = 0, frames_a = 0;
    int         last_low_a = 0, last_samp_a = 0, last_gap_a = 0;
    logic [7:0] w_a = '0;
    logic       psclk_a = 1'b0, pcs_a = 1'b1, pbusy_a = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            bits_a = 0; samp_a = 0; low_a = 0; gap_a = 0; w_a = '0;
        end else begin
            if (a_get) begin
                gets_a++;
                if (a_busy) gets_busy_a++;
                mt_a++;
                if (!step || a_empty) begin
                    mf_a++;
                    $display("FAIL get_qual_a: get=1 with step=%0b empty=%0b, required step=1 empty=0",
                             step, a_empty);
                end
            end
            if (!a_cs_n && step) low_a++;
            if (a_cs_n && a_busy && step) gap_a++;
            if (!a_cs_n && (a_sclk != psclk_a) && (a_sclk == 1'b1)) begin
                w_a = {w_a[6:0], a_mosi};
                bits_a++;
                samp_a++;
                if (bits_a == 8) begin
                    bits_a = 0;
                    mt_a++;
                    if (erd_a == ewr_a) begin
                        mf_a++;
                        $display("FAIL word_a: unexpected word dc=%0b data=%h, none expected", a_dc_o, w_a);
                    end else begin
                        if ({a_dc_o, w_a} !== exp_a[erd_a[4:0]]) begin
                            mf_a++;
                            $display("FAIL word_a: got {dc,data}=%h, expected %h", {a_dc_o, w_a}, exp_a[erd_a[4:0]]);
                        end
                        erd_a++;
                    end
                end
            end
            if (a_cs_n && !pcs_a) begin
                frames_a++;
                last_low_a  = low_a;
                last_samp_a = samp_a;
                low_a = 0; samp_a = 0;
                mt_a++;
                if (bits_a != 0) begin
                    mf_a++;
                    $display("FAIL frame_a: cs_n rose after %0d bits of a word, expected 0", bits_a);
                end
            end
            if (!a_busy && pbusy_a) begin
                last_gap_a = gap_a;
                gap_a = 0;
            end
        end
        psclk_a = a_sclk; pcs_a = a_cs_n; pbusy_a = a_busy;
    end

    // ---------------- monitor B (CPOL=1 CPHA=1, LSB first: sample on rising)
    int         mt_b = 0, mf_b = 0;
    int         bits_b = 0, samp_b = 0, low_b = 0, gap_b = 0;
    int         gets_b = 0, frames_b = 0;
    int         last_low_b = 0, last_samp_b = 0, last_gap_b = 0;
    logic [8:0] w_b = '0;
    logic       psclk_b = 1'b1, pcs_b = 1'b1, pbusy_b = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            bits_b = 0; samp_b = 0; low_b = 0; gap_b = 0; w_b = '0;
        end else begin
            if (b_get) begin
                gets_b++;
                mt_b++;
                if (!step || b_empty) begin
                    mf_b++;
                    $display("FAIL get_qual_b: get=1 with step=%0b empty=%0b, required step=1 empty=0",
                             step, b_empty);
                end
            end
            if (!b_cs_n && step) low_b++;
            if (b_cs_n && b_busy && step) gap_b++;
            if (!b_cs_n && (b_sclk != psclk_b) && (b_sclk == 1'b1)) begin
                w_b = {b_mosi, w_b[8:1]};
                bits_b++;
                samp_b++;
                if (bits_b == 9) begin
                    bits_b = 0;
                    mt_b++;
                    if (erd_b == ewr_b) begin
                        mf_b++;
                        $display("FAIL word_b: unexpected word dc=%0b data=%h, none expected", b_dc_o, w_b);
                    end else begin
                        if ({b_dc_o, w_b} !== exp_b[erd_b[4:0]]) begin
                            mf_b++;
                            $display("FAIL word_b: got {dc,data}=%h, expected %h", {b_dc_o, w_b}, exp_b[erd_b[4:0]]);
                        end
                        erd_b++;
                    end
                end
            end
            if (b_cs_n && !pcs_b) begin
                frames_b++;
                last_low_b  = low_b;
                last_samp_b = samp_b;
                low_b = 0; samp_b = 0;
                mt_b++;
                if (bits_b != 0) begin
                    mf_b++;
                    $display("FAIL frame_b: cs_n rose after %0d bits of a word, expected 0", bits_b);
                end
            end
            if (!b_busy && pbusy_b) begin
                last_gap_b = gap_b;
                gap_b = 0;
            end
        end
        psclk_b = b_sclk; pcs_b = b_cs_n; pbusy_b = b_busy;
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_a(input logic d, input logic [7:0] v, input bit expect_it);
        if (expect_it) begin
            exp_a[ewr_a[4:0]] = {d, v};
            ewr_a++;
        end
        mem_a[wr_a[4:0]] = {d, v};
        wr_a++;
    endtask

    task automatic push_b(input logic d, input logic [8:0] v);
        exp_b[ewr_b[4:0]] = {d, v};
        ewr_b++;
        mem_b[wr_b[4:0]] = {d, v};
        wr_b++;
    endtask

    // wait until the chosen source is drained and its DUT is back in IDLE
    task automatic wait_idle(input bit sel_b, input string name);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (sel_b) done = (rd_b == wr_b) && !b_busy;
            else       done = (rd_a == wr_a) && !a_busy;
            if (!done && n > 3000) begin
                check({name, "_timeout"}, 0, 1);
                done = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    int g0, gb0, f0, fb0, rd0, bad, n;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_cs_n",  a_cs_n, 1);
        check("rst_a_sclk",  a_sclk, 0);
        check("rst_a_dc",    a_dc_o, 0);
        check("rst_a_mosi",  a_mosi, 0);
        check("rst_a_busy",  a_busy, 0);
        check("rst_a_get",   a_get,  0);
        check("rst_b_cs_n",  b_cs_n, 1);
        check("rst_b_sclk",  b_sclk, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // single word A5, step every 2 clocks
        g0 = gets_a; f0 = frames_a;
        push_a(1'b0, 8'hA5, 1'b1);
        wait_idle(1'b0, "t1");
        check("t1_cs_low_steps", last_low_a, 17);
        check("t1_get_pulses",   gets_a - g0, 1);
        check("t1_frames",       frames_a - f0, 1);
        check("t1_sclk_rises",   last_samp_a, 8);
        check("t1_gap_steps",    last_gap_a, 2);
        check("t1_end_cs_n",     a_cs_n, 1);
        check("t1_end_sclk",     a_sclk, 0);

        // two words, dc changes 1 -> 0
        g0 = gets_a; gb0 = gets_busy_a; f0 = frames_a;
        push_a(1'b1, 8'h2A, 1'b1);
        push_a(1'b0, 8'h00, 1'b1);
        wait_idle(1'b0, "t2");
        check("t2_get_pulses", gets_a - g0, 2);
`ifdef SPI_DISPLAY_CS_SPLIT_EN
        check("t2_frames",        frames_a - f0, 2);
        check("t2_cs_low_steps",  last_low_a, 17);
        check("t2_chained_gets",  gets_busy_a - gb0, 0);
        check("t2_gap_steps",     last_gap_a, 2);
`else
        check("t2_frames",        frames_a - f0, 1);
        check("t2_cs_low_steps",  last_low_a, 33);
        check("t2_chained_gets",  gets_busy_a - gb0, 1);
        check("t2_sclk_rises",    last_samp_a, 16);
`endif

        // W=9, CPOL=1, CPHA=1, LSB first, same dc so always chained
        g0 = gets_b; fb0 = frames_b;
        push_b(1'b0, 9'h101);
        push_b(1'b0, 9'h0C5);
        wait_idle(1'b1, "t3");
        check("t3_get_pulses",   gets_b - g0, 2);
        check("t3_frames",       frames_b - fb0, 1);
        check("t3_cs_low_steps", last_low_b, 37);
        check("t3_sclk_rises",   last_samp_b, 18);
        check("t3_gap_steps",    last_gap_b, 3);
        check("t3_idle_sclk",    b_sclk, 1);

        // reset in the middle of a word (after 5 bits)
        push_a(1'b1, 8'hFF, 1'b0);
        n = 0;
        while (bits_a != 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t4_reached_5_bits", bits_a, 5);
        rst = 1'b1;
        #1;
        check("t4_rst_cs_n", a_cs_n, 1);
        check("t4_rst_sclk", a_sclk, 0);
        check("t4_rst_dc",   a_dc_o, 0);
        check("t4_rst_mosi", a_mosi, 0);
        check("t4_rst_busy", a_busy, 0);
        rd0 = rd_a; g0 = gets_a;
        push_a(1'b1, 8'h3C, 1'b1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_get) bad++;
        end
        check("t4_no_get_in_reset",  bad, 0);
        check("t4_no_read_in_reset", rd_a - rd0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle(1'b0, "t4");
        check("t4_get_pulses",   gets_a - g0, 1);
        check("t4_cs_low_steps", last_low_a, 17);

        // step tied high: idle with empty source, then one word at full rate
        step_always = 1'b1;
        g0 = gets_a;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_get || a_busy || !a_cs_n) bad++;
        end
        check("t5_idle_when_empty", bad, 0);
        check("t5_no_get",          gets_a - g0, 0);
        push_a(1'b0, 8'h5A, 1'b1);
        wait_idle(1'b0, "t5");
        check("t5_get_pulses",   gets_a - g0, 1);
        check("t5_cs_low_steps", last_low_a, 17);
        check("t5_gap_steps",    last_gap_a, 2);

        // every expected word must have been observed
        check("sb_a_drained", erd_a, ewr_a);
        check("sb_b_drained", erd_b, ewr_b);

        tests += mt_a + mt_b;
        fails += mf_a + mf_b;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_display_gen.md
Name: spi_display_gen

Overview:
Parametrised bit-bang SPI display transmitter. It is the next generation of the fixed 8-bit, mode-0 display driver. It pulls {dc, data} words from a FIFO/ROM-style source using a get/empty handshake and serialises them onto SPI. Width, SPI mode (CPOL/CPHA), bit order and chip-select gap are configurable. All bit timing is paced by an external step strobe from the timer block.

Parameters:
W, 8, data bits per word (1..32)
CPOL, 0, idle level of spi_clock
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
LSB_FIRST, 0, 0 = MSB shifted first; 1 = LSB first
CS_GAP, 2, step ticks spi_cs_n stays high after a frame ends before a new frame may start (1..255)

Ports:
clock  in  1  system clock, all state changes on rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
step  in  1  half-bit timing strobe; the FSM advances only on clock edges with step=1
dc  in  1  data/command flag of the presented word
data  in  W  presented word
empty  in  1  source has no word; dc/data are valid only when empty=0
get  out  1  combinational one-cycle consume pulse
spi_cs_n  out  1  chip select, active low
spi_clock  out  1  SPI clock
spi_dc  out  1  data/command line, held for the whole word
spi_mosi  out  1  serial data out
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: spi_cs_n=1, spi_clock=CPOL, spi_dc=0, spi_mosi=0, busy=0, FSM=IDLE, bit counter=0, gap counter=0. Reset mid-frame aborts immediately with no partial bits resumed. The in-flight word is lost; it was already consumed.
- All outputs except get are registered.
- get = step & ~empty & (state==IDLE | (state==SHIFT & last bit & phase==B)). It is never high when empty=0 is not true or step=0. The source presents the next word on the clock after get.
- States: IDLE, SHIFT, HOLD, GAP.
- IDLE, on step & ~empty: latch data into shift register and dc into spi_dc; spi_cs_n<=0; drive first bit on spi_mosi; phase<=A; bit counter<=W-1; go to SHIFT.
- SHIFT: each bit takes two step ticks, phase A then phase B.
  - spi_clock = CPOL ^ CPHA ^ (phase==B).
  - spi_mosi changes only on entry to phase A.
  - On phase B of the last bit: if ~empty, latch the next word (get=1), stay in SHIFT with spi_cs_n kept low and no idle step. Otherwise go to HOLD.
- HOLD: one step tick with spi_clock=CPOL and spi_cs_n=0. Then spi_cs_n<=1, gap counter<=CS_GAP, go to GAP.
- GAP: decrement on each step; at 1 go to IDLE. Words arriving during GAP wait and get stays 0.
- Frame timing: one isolated word holds spi_cs_n low for 2W+1 steps. Minimum restart latency after cs_n rises is CS_GAP steps.
- step held constantly high is legal: one half-bit per clock.
- empty rising mid-word does not affect the current word.
- LSB_FIRST selects shift direction only; the counter is unchanged.

Optional Feature:
SPI_DISPLAY_CS_SPLIT_EN
- Defined: when the next word is available at the end of a word but its dc differs from the current spi_dc, do not chain. Assert no get, go to HOLD→GAP, and start the word from IDLE afterwards. spi_cs_n therefore toggles at every dc change.
- Undefined: chaining ignores dc; spi_dc simply updates at the word boundary under a continuous spi_cs_n low.

Test Plan:
- W=8, CPOL=0, CPHA=0, single word {0,8'hA5}, step every 2 clocks → spi_mosi bits 1,0,1,0,0,1,0,1; 8 rising spi_clock edges, each mid-bit; spi_cs_n low 17 steps; get pulsed once; then IDLE.
- Two words {1,8'h2A},{0,8'h00} back-to-back, macro undefined → spi_cs_n stays low 33 steps; spi_dc 1→0 at the boundary; exactly 2 get pulses.
- Same stimulus with SPI_DISPLAY_CS_SPLIT_EN → spi_cs_n high for CS_GAP=2 steps between words; second get only after the gap.
- CPOL=1, CPHA=1, LSB_FIRST=1, W=9, word 9'h101 → idle spi_clock=1; mosi 1,0,0,0,0,0,0,0,1; data stable on each rising (trailing) edge.
- Reset asserted mid-word (after 5 bits) → next clock all outputs at reset values; source not re-read until the first step after reset release.
- step tied high with source empty → no get, busy=0, spi_cs_n=1 indefinitely.
